// File: rtl/config_loader_if.sv
// rtl/config_loader_if.sv - stream input and tile-array broadcast bundle for config_loader
//
// Signals:
//   in_data[31:0]      configuration stream word
//   in_valid           in_data is valid
//   in_ready           loader accepts in_data this cycle
//   config_addr[31:0]  broadcast configuration address to the tile array
//   config_data[31:0]  broadcast configuration data to the tile array
//   busy               loader is not idle
//   done               one-cycle pulse at the end of a stream
//   error              sticky stream-format error flag
// Modports:
//   master  stream source / observer of the loader outputs
//   slave   the loader itself
interface config_loader_if;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] config_addr;
    logic [31:0] config_data;
    logic        busy;
    logic        done;
    logic        error;

    modport master (
        output in_data, in_valid,
        input  in_ready, config_addr, config_data, busy, done, error
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, config_addr, config_data, busy, done, error
    );
endinterface

// File: rtl/config_loader.sv
// rtl/config_loader.sv - streams (address, data) pairs from a framed input into tile-array config writes
//
// Parameters:
//   IDLE_ADDR    config_addr value when no write is driven; matches no tile
//   HOLD_CYCLES  cycles each write is driven (1..15)
// Ports:
//   clk    single clock, rising edge
//   reset  asynchronous, active-low reset
//   bus    config_loader_if.slave (stream in, broadcast out, status)
// Build option:
//   CONFIG_LOADER_CHECKSUM_EN  appends a checksum word to the stream and checks it
//                              against the XOR of every address and data word
module config_loader #(
    parameter logic [31:0] IDLE_ADDR   = 32'hFFFF_FFFF,
    parameter int          HOLD_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    config_loader_if.slave   bus
);

    localparam logic [15:0] MAGIC = 16'hC0F1;

    typedef enum logic [2:0] {
        IDLE,
        GET_ADDR,
        GET_DATA,
        DRIVE,
        CHECK,
        DONE
    } state_t;

`ifdef CONFIG_LOADER_CHECKSUM_EN
    localparam state_t END_STATE = CHECK;
`else
    localparam state_t END_STATE = DONE;
`endif

    state_t      state;
    state_t      state_next;
    logic [15:0] pair_cnt;
    logic [31:0] addr_q;
    logic [3:0]  hold_cnt;
    logic        ready;
    logic        xfer;
    logic        magic_ok;
    logic [15:0] hdr_n;

    logic [31:0] config_addr_q;
    logic [31:0] config_data_q;
    logic        busy_q;
    logic        done_q;
    logic        error_q;

`ifdef CONFIG_LOADER_CHECKSUM_EN
    logic [31:0] csum;
`endif

    // in_ready is a pure state decode, so xfer never loops back into itself
    assign ready    = (state == IDLE) || (state == GET_ADDR) ||
                      (state == GET_DATA) || (state == CHECK);
    assign xfer     = bus.in_valid && ready;
    assign magic_ok = (bus.in_data[31:16] == MAGIC);
    assign hdr_n    = bus.in_data[15:0];

    assign bus.in_ready    = ready;
    assign bus.config_addr = config_addr_q;
    assign bus.config_data = config_data_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.error       = error_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (xfer && magic_ok) begin
                    state_next = (hdr_n == 16'd0) ? END_STATE : GET_ADDR;
                end
            end
            GET_ADDR: begin
                if (xfer) begin
                    state_next = GET_DATA;
                end
            end
            GET_DATA: begin
                if (xfer) begin
                    // A pair aimed at IDLE_ADDR is consumed silently; the counter
                    // has not been decremented yet, so "last pair" is pair_cnt == 1.
                    if (addr_q == IDLE_ADDR) begin
                        state_next = (pair_cnt == 16'd1) ? END_STATE : GET_ADDR;
                    end else begin
                        state_next = DRIVE;
                    end
                end
            end
            DRIVE: begin
                if (hold_cnt == 4'd0) begin
                    state_next = (pair_cnt == 16'd0) ? END_STATE : GET_ADDR;
                end
            end
            CHECK: begin
                if (xfer) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pair_cnt      <= 16'd0;
            addr_q        <= 32'd0;
            hold_cnt      <= 4'd0;
            config_addr_q <= IDLE_ADDR;
            config_data_q <= 32'd0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
`ifdef CONFIG_LOADER_CHECKSUM_EN
            csum          <= 32'd0;
`endif
        end else begin
            if (state == IDLE && xfer) begin
                if (magic_ok) begin
                    pair_cnt <= hdr_n;
                    error_q  <= 1'b0;
`ifdef CONFIG_LOADER_CHECKSUM_EN
                    csum     <= 32'd0;
`endif
                end else begin
                    error_q  <= 1'b1;
                end
            end

            if (state == GET_ADDR && xfer) begin
                addr_q <= bus.in_data;
`ifdef CONFIG_LOADER_CHECKSUM_EN
                csum   <= csum ^ bus.in_data;
`endif
            end

            if (state == GET_DATA && xfer) begin
                pair_cnt <= pair_cnt - 16'd1;
`ifdef CONFIG_LOADER_CHECKSUM_EN
                csum     <= csum ^ bus.in_data;
`endif
            end

`ifdef CONFIG_LOADER_CHECKSUM_EN
            if (state == CHECK && xfer && (bus.in_data != csum)) begin
                error_q <= 1'b1;
            end
`endif

            // DRIVE is only entered from GET_DATA on the data-word transfer,
            // so the data word is taken straight from the bus on that edge.
            if (state_next == DRIVE) begin
                if (state != DRIVE) begin
                    config_addr_q <= addr_q;
                    config_data_q <= bus.in_data;
                    hold_cnt      <= 4'(HOLD_CYCLES - 1);
                end else begin
                    hold_cnt      <= hold_cnt - 4'd1;
                end
            end else begin
                config_addr_q <= IDLE_ADDR;
                config_data_q <= 32'd0;
            end

            busy_q <= (state_next != IDLE);
            done_q <= (state_next == DONE);
        end
    end

endmodule

// File: doc/config_loader.md
CONFIG_LOADER -- requirements
Module: config_loader

Interface
REQ-001 Parameter IDLE_ADDR, default 32'hFFFF_FFFF, config_addr value driven when no write is in progress; it matches no tile.
REQ-002 Parameter HOLD_CYCLES, default 1, number of cycles each write is driven; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 in_data  input  32  configuration stream word.
REQ-006 in_valid  input  1  in_data is valid.
REQ-007 in_ready  output  1  loader accepts in_data this cycle.
REQ-008 config_addr  output  32  broadcast configuration address to the tile array.
REQ-009 config_data  output  32  broadcast configuration data to the tile array.
REQ-010 busy  output  1  high in any state other than IDLE.
REQ-011 done  output  1  one-cycle pulse at the end of a stream.
REQ-012 error  output  1  sticky stream-format error flag.

Function
REQ-013 A word transfers on a rising clk edge where in_valid and in_ready are both high; in_data is ignored at all other times.
REQ-014 Stream format: header word with [31:16] = 16'hC0F1 and [15:0] = N pair count, followed by N (address word, data word) pairs, followed by the checksum word only when the checksum feature is compiled in.
REQ-015 States: IDLE, GET_ADDR, GET_DATA, DRIVE, CHECK, DONE.
REQ-016 in_ready is high in IDLE, GET_ADDR, GET_DATA and CHECK, and low in DRIVE and DONE.
REQ-017 IDLE, header with correct magic and N>0: load the remaining-pair counter with N, clear error, go to GET_ADDR.
REQ-018 IDLE, header with correct magic and N=0: clear error, go to CHECK if the checksum feature is compiled in, otherwise go to DONE.
REQ-019 IDLE, header with wrong magic: discard the word, set error, stay in IDLE.
REQ-020 GET_ADDR: capture the address word, go to GET_DATA.
REQ-021 GET_DATA: capture the data word and decrement the counter; go to DRIVE, unless the captured address equals IDLE_ADDR.
REQ-022 Address equal to IDLE_ADDR: the pair is consumed and counted but not driven; the FSM takes the post-DRIVE transition directly.
REQ-023 DRIVE: config_addr and config_data carry the captured pair for exactly HOLD_CYCLES cycles, starting the cycle after the data-word transfer.
REQ-024 Post-DRIVE transition, counter nonzero: go to GET_ADDR.
REQ-025 Post-DRIVE transition, counter zero: go to CHECK if the checksum feature is compiled in, otherwise go to DONE.
REQ-026 Outside DRIVE: config_addr = IDLE_ADDR and config_data = 0.
REQ-027 Outputs are registered; no in_data-to-output combinational path exists.
REQ-028 DONE: done is high for exactly that one cycle, then the FSM goes to IDLE.
REQ-029 in_valid low in any input-accepting state: the FSM holds its state and all captured data.
REQ-030 The counter is 16 bits; N=16'hFFFF is legal and never wraps.
REQ-031 error stays set until reset or until the next header with correct magic is accepted.

Reset
REQ-032 While reset is low, asynchronously: state = IDLE, counter = 0, config_addr = IDLE_ADDR, config_data = 0, done = 0, error = 0, busy = 0.
REQ-033 in_ready is high immediately after reset deasserts.
REQ-034 Reset mid-stream drops any partial pair; the tile array sees no further write from it.

Configuration
REQ-035 Macro CONFIG_LOADER_CHECKSUM_EN defined: a running XOR covers every address and data word of the stream and is cleared on header acceptance.
REQ-036 With CONFIG_LOADER_CHECKSUM_EN, CHECK accepts one word; a mismatch sets error; done pulses whether or not the checksum matches.
REQ-037 Macro undefined: no checksum logic is built, CHECK is unreachable, and error is set only by a wrong magic header.

Verification
REQ-038 Header 32'hC0F1_0002, pairs (0x0001_0004, 0xDEAD_BEEF) and (0x0002_0008, 0x1234_5678), HOLD_CYCLES=1 -> each pair is driven for one cycle, in order, with in_ready low during each drive; one done pulse; error=0.
REQ-039 Header 32'hBAD0_0001 -> error=1, state stays IDLE, config_addr stays 32'hFFFF_FFFF; a following valid header clears error.
REQ-040 Header 32'hC0F1_0001, pair (32'hFFFF_FFFF, 0x55) -> no drive cycle; done pulses.
REQ-041 in_valid toggled randomly, HOLD_CYCLES=3 -> driven pairs match the uninterrupted run; each pair is held exactly 3 cycles.
REQ-042 reset pulsed low during GET_DATA -> outputs return to idle values asynchronously; the captured address is never driven.
REQ-043 With CONFIG_LOADER_CHECKSUM_EN, header 32'hC0F1_0001, pair (0x1, 0x2), checksum 0x3 -> error=0; same stream with checksum 0x4 -> error=1; done pulses in both cases.
